// File: rtl/mmult_param_if.sv
// mmult_param_if: handshake and operand/result bus of the N x N matrix multiplier
//   master: drives start, a_mat, b_mat, ack; sees busy, valid, c_mat
//   slave : the multiplier side of the same signals
interface mmult_param_if #(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
);
    logic                 start;
    logic                 ack;
    logic                 busy;
    logic                 valid;
    logic [N*N*DW-1:0]    a_mat;
    logic [N*N*DW-1:0]    b_mat;
    logic [N*N*ACC_W-1:0] c_mat;

    modport master (output start, a_mat, b_mat, ack, input busy, valid, c_mat);
    modport slave  (input start, a_mat, b_mat, ack, output busy, valid, c_mat);
endinterface

// File: rtl/mmult_param.sv
// mmult_param: N x N integer matrix multiplier C = A x B, one result element per cycle
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   bus.slave start/a_mat/b_mat/ack in, busy/valid/c_mat out; matrices row-major, element 0 at MSB end
//   MMULT_SIGNED_EN: when defined, operands and results are two's-complement
module mmult_param #(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N)
) (
    input logic          clk,
    input logic          reset_n,
    mmult_param_if.slave bus
);
    localparam int NN = N*N;
    localparam int KW = $clog2(NN);
    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state, state_nx;
    logic [KW-1:0]    k;
    logic [RW-1:0]    row, col;
    logic [DW-1:0]    a_el [N][N];
    logic [DW-1:0]    b_el [N][N];
    logic [ACC_W-1:0] c_el [NN];
    logic [ACC_W-1:0] dot;
    logic             last;

    // Extending to ACC_W before multiplying keeps the low ACC_W bits of every
    // product exact in both unsigned and two's-complement arithmetic.
    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] x);
`ifdef MMULT_SIGNED_EN
        return ACC_W'($signed(x));
`else
        return ACC_W'(x);
`endif
    endfunction

    assign last = (k == KW'(NN-1));

    always_comb begin
        dot = '0;
        for (int j = 0; j < N; j++)
            dot = dot + ext(a_el[row][j]) * ext(b_el[j][col]);
    end

    always_comb begin
        bus.c_mat = '0;
        for (int i = 0; i < NN; i++)
            bus.c_mat[(NN-i)*ACC_W-1 -: ACC_W] = c_el[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bus.busy  = 1'b0;
        bus.valid = 1'b0;
        case (state)
            IDLE:    state_nx = bus.start ? COMPUTE : IDLE;
            COMPUTE: begin
                bus.busy = 1'b1;
                state_nx = last ? DONE : COMPUTE;
            end
            DONE:    begin
                bus.busy  = 1'b1;
                bus.valid = 1'b1;
                state_nx  = bus.ack ? IDLE : DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // row/col track k/N and k%N so no divider is needed; k holds at the last element.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k   <= '0;
            row <= '0;
            col <= '0;
            for (int i = 0; i < NN; i++)
                c_el[i] <= '0;
        end else if (state == IDLE && bus.start) begin
            k   <= '0;
            row <= '0;
            col <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_el[r][c] <= bus.a_mat[(NN-(r*N+c))*DW-1 -: DW];
                    b_el[r][c] <= bus.b_mat[(NN-(r*N+c))*DW-1 -: DW];
                end
        end else if (state == COMPUTE) begin
            c_el[k] <= dot;
            if (!last) begin
                k   <= k + 1'b1;
                col <= (col == RW'(N-1)) ? '0 : col + 1'b1;
                row <= (col == RW'(N-1)) ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: doc/mmult_param.md
Name: mmult_param

Overview:
- Parametrised N×N integer matrix multiplier, C = A × B, with a start/valid/ack handshake.
- Next generation of the team's fixed 3×3/8-bit multiplier. Generalises matrix size and operand width, and adds a busy flag, an explicit result-hold/acknowledge phase and optional signed mode.
- Computes one output element per cycle using N parallel multipliers and an adder tree. Sits between the operand register bank and the result display/UART path.

Parameters:
- N, 3, matrix dimension (2..8).
- DW, 8, operand element width in bits.
- ACC_W, 2*DW+$clog2(N), result element width; must be ≥ 2*DW+$clog2(N). Default gives 18 for N=3, DW=8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a_mat  input  N*N*DW  matrix A, row-major; element idx=r*N+c at bits [(N*N-idx)*DW-1 -: DW], so element 0 is at the MSB end.
- b_mat  input  N*N*DW  matrix B, same packing as a_mat.
- ack  input  1  consumer has read c_mat; sampled only in DONE.
- busy  output  1  high in COMPUTE and DONE.
- valid  output  1  high only in DONE.
- c_mat  output  N*N*ACC_W  result, same row-major MSB-first packing with ACC_W-bit elements.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; valid=0; busy=0; c_mat=0; element counter k=0.
  - Applies from any state. A mid-operation reset aborts the multiply and no partial result is flagged valid.
- IDLE:
  - On an edge with start=1: latch a_mat and b_mat into internal registers, set k=0, go to COMPUTE.
  - Operands are not re-sampled afterwards, so input changes during COMPUTE have no effect.
- COMPUTE:
  - Each edge writes c_mat element k = sum over j of A[k/N][j]*B[j][k%N], then increments k.
  - Elements are written in row-major order, k=0..N*N-1. Unwritten elements keep their previous values.
  - The edge that writes k=N*N-1 also moves the state to DONE.
- DONE:
  - valid=1; c_mat and valid are held stable indefinitely.
  - On an edge with ack=1: go to IDLE, valid=0. c_mat keeps the last result until the next multiply overwrites it.
- Latency:
  - Start edge = edge 0. Element k is written at edge k+1. valid is high after edge N*N (edge 9 for N=3).
  - Minimum start-to-start period is N*N+2 edges: N*N compute edges, one ack edge, one start edge.
- start handling:
  - start is ignored in COMPUTE and DONE; it is not queued.
  - start held high through an ack edge does not restart on that edge. A new multiply begins on the next edge seen in IDLE.
- ack in IDLE or COMPUTE is ignored. Simultaneous start and ack in DONE: ack is honoured, start is ignored.
- Arithmetic:
  - Default unsigned. Products are zero-extended to ACC_W and summed with no saturation.
  - The ACC_W rule guarantees no overflow.
- Counter k is $clog2(N*N) bits wide and never wraps past N*N-1.

Optional Feature:
- Macro MMULT_SIGNED_EN.
- Defined: operands are two's-complement. Products and sums are sign-extended to ACC_W, and c_mat elements are two's-complement.
- Undefined: all operands and results are unsigned, as described above.
- Timing and handshake are identical in both builds.

Test Plan:
- Latency (N=3): A=identity, B=elements 1..9; pulse start. Required:
  - c_mat = 1..9;
  - valid rises after edge 9;
  - busy is high from edge 0 until the ack edge.
- Maximum unsigned (N=3, DW=8): all elements of A and B = 255. Required: every C element = 195075 (0x2FA03); no overflow in 18 bits.
- Signed build, MMULT_SIGNED_EN defined: all elements of A and B = -128. Required: every C element = 49152; A all -1 with B all 5 gives every C element = -15 (0x3FFF1).
- Handshake: hold ack=0 for 20 cycles after valid, and toggle start and a_mat during COMPUTE. Required:
  - valid and c_mat stay stable;
  - no restart occurs;
  - after ack, valid=0 next cycle;
  - a second start produces the result from the new operands.
- Reset mid-operation: assert reset_n=0 at edge 4 of COMPUTE. Required:
  - next cycle state=IDLE, valid=0, busy=0, c_mat=0;
  - a following start completes normally with the correct result.
- Parameter sweep: N=2/DW=4 and N=4/DW=16 with random matrices. Required: c_mat matches the reference model, and valid rises after edges 4 and 16 respectively.
